// File: rtl/riscv_pkg.sv
// Shared pipeline-control types for hazard_ctrl.
// ST_DIV_WAIT only exists when HAZARD_DIV_STALL_EN is defined.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1
`ifdef HAZARD_DIV_STALL_EN
    , ST_DIV_WAIT = 2'd2
`endif
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Load-use hazard: the load's destination is read by the ID instruction.
  // x0 is never a real dependency.
  function automatic logic load_use_hazard(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       use_rs1,
    input logic       use_rs2
  );
    return mem_read && (rd != REG_X0) &&
           ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with async reset, sync clear and count enable.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/trap flushes and
// optional divide stall (enabled by macro HAZARD_DIV_STALL_EN).
module hazard_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memRead,
  input  logic [4:0]  idex_addr_rd,
  input  logic        idex_is_div,
  input  logic [4:0]  ifid_addr_rs1,
  input  logic [4:0]  ifid_addr_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  input  logic        branch_taken,
  input  logic        trap_req,
  input  logic        div_done,
  output logic        PC_write,
  output logic        IFID_write,
  output logic        IDEX_write,
  output logic        flush_branch,
  output logic        flush_trap,
  output logic        div_start,
  output logic        div_kill,
  output logic [31:0] stall_cycles
);

  hz_state_t state;
  hz_state_t state_next;
  logic      hazard;
  logic      advance;
  logic      stall_en;

`ifndef HAZARD_DIV_STALL_EN
  logic unused_div;
  assign unused_div = idex_is_div ^ div_done;
`endif

  assign hazard = load_use_hazard(idex_memRead, idex_addr_rd, ifid_addr_rs1,
                                  ifid_addr_rs2, ifid_use_rs1, ifid_use_rs2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are gated by reset so the pipeline keeps running (and the
  // divider is not killed) while reset is held.
  always_comb begin
    state_next   = state;
    advance      = 1'b1;
    flush_branch = 1'b0;
    flush_trap   = 1'b0;
    div_start    = 1'b0;
    div_kill     = 1'b0;
    if (reset) begin
      state_next = ST_RUN;
    end else if (trap_req) begin
      flush_trap = 1'b1;
      state_next = ST_RUN;
`ifdef HAZARD_DIV_STALL_EN
      div_kill   = (state == ST_DIV_WAIT);
`endif
    end else begin
      case (state)
        ST_RUN: begin
          if (branch_taken) begin
            flush_branch = 1'b1;
          end
`ifdef HAZARD_DIV_STALL_EN
          else if (idex_is_div) begin
            div_start  = 1'b1;
            advance    = 1'b0;
            state_next = ST_DIV_WAIT;
          end
`endif
          else if (hazard) begin
            advance    = 1'b0;
            state_next = ST_LOAD_STALL;
          end
        end
        ST_LOAD_STALL: begin
          state_next = ST_RUN;
        end
`ifdef HAZARD_DIV_STALL_EN
        ST_DIV_WAIT: begin
          if (div_done) begin
            state_next = ST_RUN;
          end else begin
            advance = 1'b0;
          end
        end
`endif
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  assign PC_write   = advance;
  assign IFID_write = advance;
  assign IDEX_write = advance;

  assign stall_en = !advance && !flush_branch && !flush_trap;

  sat_counter #(
    .WIDTH(32)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr  (1'b0),
    .en   (stall_en),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed table, hand sequences for
// divide/reset/saturation corners, then random traffic against a model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        idex_memRead;
  logic [4:0]  idex_addr_rd;
  logic        idex_is_div;
  logic [4:0]  ifid_addr_rs1;
  logic [4:0]  ifid_addr_rs2;
  logic        ifid_use_rs1;
  logic        ifid_use_rs2;
  logic        branch_taken;
  logic        trap_req;
  logic        div_done;
  logic        PC_write;
  logic        IFID_write;
  logic        IDEX_write;
  logic        flush_branch;
  logic        flush_trap;
  logic        div_start;
  logic        div_kill;
  logic [31:0] stall_cycles;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .idex_memRead (idex_memRead),
    .idex_addr_rd (idex_addr_rd),
    .idex_is_div  (idex_is_div),
    .ifid_addr_rs1(ifid_addr_rs1),
    .ifid_addr_rs2(ifid_addr_rs2),
    .ifid_use_rs1 (ifid_use_rs1),
    .ifid_use_rs2 (ifid_use_rs2),
    .branch_taken (branch_taken),
    .trap_req     (trap_req),
    .div_done     (div_done),
    .PC_write     (PC_write),
    .IFID_write   (IFID_write),
    .IDEX_write   (IDEX_write),
    .flush_branch (flush_branch),
    .flush_trap   (flush_trap),
    .div_start    (div_start),
    .div_kill     (div_kill),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mem_read;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       is_div;
    logic       branch;
    logic       trap;
    logic       done;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [6:0]  eo;
    logic [31:0] ec;
    string       name;
  } vec_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: pending load bubble, outstanding divide, stall count.
  bit              m_lstall;
  bit              m_dbusy;
  longint unsigned m_cnt;

  function automatic stim_t mk(input logic mr, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic dv,
                               input logic br, input logic tr, input logic dn);
    stim_t s;
    s.mem_read = mr; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.use1 = u1; s.use2 = u2; s.is_div = dv;
    s.branch = br; s.trap = tr; s.done = dn;
    return s;
  endfunction

  // {PC_write, IFID_write, IDEX_write, flush_branch, flush_trap, div_start, div_kill}
  function automatic logic [6:0] eo(input logic w, input logic fb, input logic ft,
                                    input logic ds, input logic dk);
    return {w, w, w, fb, ft, ds, dk};
  endfunction

  function automatic logic [6:0] dut_outs();
    return {PC_write, IFID_write, IDEX_write, flush_branch, flush_trap, div_start, div_kill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    idex_memRead  = s.mem_read;
    idex_addr_rd  = s.rd;
    ifid_addr_rs1 = s.rs1;
    ifid_addr_rs2 = s.rs2;
    ifid_use_rs1  = s.use1;
    ifid_use_rs2  = s.use2;
    idex_is_div   = s.is_div;
    branch_taken  = s.branch;
    trap_req      = s.trap;
    div_done      = s.done;
  endtask

  task automatic model_reset();
    m_lstall = 1'b0;
    m_dbusy  = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_step(input stim_t s, output logic [6:0] e);
    logic haz, w, fb, ft, ds, dk;
    haz = s.mem_read && (s.rd != 5'd0) &&
          ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
    w = 1'b1; fb = 1'b0; ft = 1'b0; ds = 1'b0; dk = 1'b0;
    if (s.trap) begin
      ft = 1'b1; dk = m_dbusy; m_dbusy = 1'b0; m_lstall = 1'b0;
    end else if (m_dbusy) begin
      if (s.done) m_dbusy = 1'b0;
      else        w = 1'b0;
    end else if (m_lstall) begin
      m_lstall = 1'b0;
    end else if (s.branch) begin
      fb = 1'b1;
`ifdef HAZARD_DIV_STALL_EN
    end else if (s.is_div) begin
      ds = 1'b1; w = 1'b0; m_dbusy = 1'b1;
`endif
    end else if (haz) begin
      w = 1'b0; m_lstall = 1'b1;
    end
    if (!w && !fb && !ft && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
    e = eo(w, fb, ft, ds, dk);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply(input stim_t s, input bit use_model, input logic [6:0] exp_o,
                       input logic [31:0] exp_c, input string name);
    logic [6:0] me;
    drive(s);
    #1;
    model_step(s, me);
    check({name, ".outs"}, {25'd0, dut_outs()}, {25'd0, (use_model ? me : exp_o)});
    @(posedge clk);
    #1;
    check({name, ".cnt"}, stall_cycles, (use_model ? m_cnt[31:0] : exp_c));
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk(1, 5, 5, 0, 1, 0, 1, 0, 0, 1));
    #1;
    check("reset.outs", {25'd0, dut_outs()}, {25'd0, eo(1, 0, 0, 0, 0)});
    check("reset.cnt", stall_cycles, 32'd0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    model_reset();
  endtask

  vec_t  tbl[16];
  stim_t idle, hz5, dv, st;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    hz5  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0);
    dv   = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    tbl[0]  = '{mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0), eo(1, 0, 0, 0, 0), 32'd0, "load_x0"};
    tbl[1]  = '{hz5,                              eo(0, 0, 0, 0, 0), 32'd1, "load_x5_stall"};
    tbl[2]  = '{hz5,                              eo(1, 0, 0, 0, 0), 32'd1, "load_x5_held"};
    tbl[3]  = '{mk(1, 7, 1, 7, 0, 1, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 32'd2, "rs2_stall"};
    tbl[4]  = '{mk(1, 7, 1, 7, 0, 1, 0, 0, 0, 0), eo(1, 0, 0, 0, 0), 32'd2, "rs2_held"};
    tbl[5]  = '{mk(1, 7, 1, 7, 0, 0, 0, 0, 0, 0), eo(1, 0, 0, 0, 0), 32'd2, "rs2_unused"};
    tbl[6]  = '{mk(1, 9, 9, 0, 1, 0, 0, 1, 0, 0), eo(1, 1, 0, 0, 0), 32'd2, "branch_vs_hazard"};
    tbl[7]  = '{mk(0, 3, 3, 3, 1, 1, 0, 0, 0, 0), eo(1, 0, 0, 0, 0), 32'd2, "no_load"};
    tbl[8]  = '{mk(1, 4, 4, 0, 1, 0, 0, 0, 1, 0), eo(1, 0, 1, 0, 0), 32'd2, "trap_vs_hazard"};
    tbl[9]  = '{mk(1, 31, 1, 31, 1, 1, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 32'd3, "x31_stall"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), eo(1, 0, 1, 0, 0), 32'd3, "trap_in_lstall"};
    tbl[11] = '{mk(1, 12, 12, 0, 1, 0, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 32'd4, "stall_after_trap"};
    tbl[12] = '{idle,                             eo(1, 0, 0, 0, 0), 32'd4, "lstall_release"};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), eo(1, 0, 0, 0, 0), 32'd4, "done_in_run"};
    tbl[14] = '{mk(1, 2, 0, 2, 1, 1, 0, 0, 0, 0), eo(0, 0, 0, 0, 0), 32'd5, "rs1_x0_rs2_hit"};
    tbl[15] = '{idle,                             eo(1, 0, 0, 0, 0), 32'd5, "idle"};

    reset = 1'b1;
    drive(idle);
    model_reset();
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) apply(tbl[i].s, 1'b0, tbl[i].eo, tbl[i].ec, tbl[i].name);

`ifdef HAZARD_DIV_STALL_EN
    // Divide completing after 10 stalled cycles; a branch mid-wait is ignored.
    do_reset();
    apply(dv, 1'b0, eo(0, 0, 0, 1, 0), 32'd1, "div_start");
    for (int i = 1; i <= 9; i++) begin
      st = dv;
      st.branch = (i == 5);
      apply(st, 1'b0, eo(0, 0, 0, 0, 0), 32'(i + 1), "div_wait");
    end
    st = dv;
    st.done = 1'b1;
    apply(st, 1'b0, eo(1, 0, 0, 0, 0), 32'd10, "div_done");
    apply(idle, 1'b0, eo(1, 0, 0, 0, 0), 32'd10, "div_after");

    // Trap on the 4th DIV_WAIT cycle kills the divide.
    do_reset();
    apply(dv, 1'b0, eo(0, 0, 0, 1, 0), 32'd1, "k_start");
    for (int i = 1; i <= 3; i++) apply(dv, 1'b0, eo(0, 0, 0, 0, 0), 32'(i + 1), "k_wait");
    st = dv;
    st.trap = 1'b1;
    apply(st, 1'b0, eo(1, 0, 1, 0, 1), 32'd4, "k_trap");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, eo(1, 1, 0, 0, 0), 32'd4, "k_run");

    // Reset during a divide: no kill pulse, back in RUN.
    do_reset();
    apply(dv, 1'b0, eo(0, 0, 0, 1, 0), 32'd1, "r_start");
    apply(dv, 1'b0, eo(0, 0, 0, 0, 0), 32'd2, "r_wait");
    drive(dv);
    reset = 1'b1;
    #1;
    check("r_reset.outs", {25'd0, dut_outs()}, {25'd0, eo(1, 0, 0, 0, 0)});
    check("r_reset.cnt", stall_cycles, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, eo(1, 1, 0, 0, 0), 32'd0, "r_run");
`else
    do_reset();
    apply(dv, 1'b0, eo(1, 0, 0, 0, 0), 32'd0, "nodiv_ignored");
    st = dv;
    st.done = 1'b1;
    apply(st, 1'b0, eo(1, 0, 0, 0, 0), 32'd0, "nodiv_done");
    st = hz5;
    st.is_div = 1'b1;
    apply(st, 1'b0, eo(0, 0, 0, 0, 0), 32'd1, "nodiv_hazard");
`endif

    // Saturation: preload the counter, keep stalling, then reset in LOAD_STALL.
    do_reset();
    force dut.u_stall_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.count;
    m_cnt = 64'h0000_0000_FFFF_FFFF;
    check("sat.preload", stall_cycles, 32'hFFFF_FFFF);
    @(negedge clk);
    apply(hz5, 1'b0, eo(0, 0, 0, 0, 0), 32'hFFFF_FFFF, "sat1");
    apply(hz5, 1'b0, eo(1, 0, 0, 0, 0), 32'hFFFF_FFFF, "sat2");
    apply(hz5, 1'b0, eo(0, 0, 0, 0, 0), 32'hFFFF_FFFF, "sat3");
    drive(hz5);
    reset = 1'b1;
    #1;
    check("sat_reset.cnt", stall_cycles, 32'd0);
    check("sat_reset.outs", {25'd0, dut_outs()}, {25'd0, eo(1, 0, 0, 0, 0)});
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(hz5, 1'b0, eo(0, 0, 0, 0, 0), 32'd1, "sat_run");

    // Random traffic against the model; small register range keeps hazards frequent.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      st.mem_read = ($urandom_range(0, 1) == 1);
      st.rd       = 5'($urandom_range(0, 3));
      st.rs1      = 5'($urandom_range(0, 3));
      st.rs2      = 5'($urandom_range(0, 3));
      st.use1     = ($urandom_range(0, 1) == 1);
      st.use2     = ($urandom_range(0, 1) == 1);
      st.is_div   = ($urandom_range(0, 7) == 0);
      st.branch   = ($urandom_range(0, 7) == 0);
      st.trap     = ($urandom_range(0, 19) == 0);
      st.done     = ($urandom_range(0, 3) == 0);
      apply(st, 1'b1, 7'd0, 32'd0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
